// File: rtl/dmem_mmio_arbiter.sv
// Processor-priority arbiter for the dmem RAM with a read-only aux port and a debounced button MMIO register.
// Load data returns 1 cycle after the request; aux data 1 cycle after grant; aux waits (never dropped) while the processor owns RAM.
module dmem_mmio_arbiter #(
  parameter int BTN_ADDR        = 24,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STARVE_LIMIT    = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        proc_req,
  input  logic        proc_wren,
  input  logic [31:0] proc_addr,
  input  logic [31:0] proc_data,
  output logic [31:0] proc_q,
  input  logic        aux_req,
  input  logic [11:0] aux_addr,
  output logic        aux_gnt,
  output logic        aux_valid,
  output logic [31:0] aux_q,
  output logic        aux_starved,
  output logic        ram_wEn,
  output logic [11:0] ram_addr,
  output logic [31:0] ram_dataIn,
  input  logic [31:0] ram_dataOut,
  input  logic        btn_raw,
  output logic        btn_level
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [DW-1:0] DEB_MAX    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {AUX_IDLE, AUX_WAIT, AUX_RET} aux_state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_RAM, SRC_MMIO} src_t;

  aux_state_t     aux_state_q, aux_state_d;
  src_t           src_q, src_d;
  logic [11:0]    aux_addr_q, aux_addr_d;
  logic [31:0]    aux_q_q, aux_q_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic           sync1_q, sync2_q;
  logic [DW-1:0]  deb_cnt_q, deb_cnt_d;
  logic           btn_level_q, btn_level_d;
  logic           sticky_q, sticky_d;
  logic           mmio_q_q, mmio_q_d;

  logic is_btn, proc_ram, proc_mmio;

  // Gating with reset keeps every output at 0 while reset is held, even with proc_req high.
  assign is_btn    = (proc_addr == 32'(BTN_ADDR));
  assign proc_ram  = reset & proc_req & (proc_addr < 32'd4096) & ~is_btn;
  assign proc_mmio = reset & proc_req & is_btn;

  always_comb begin
    ram_wEn    = 1'b0;
    ram_addr   = '0;
    ram_dataIn = '0;
    aux_gnt    = 1'b0;
    if (proc_ram) begin
      ram_wEn    = proc_wren;
      ram_addr   = proc_addr[11:0];
      ram_dataIn = proc_data;
    end else if (aux_state_q == AUX_WAIT) begin
      ram_addr = aux_addr_q;
      aux_gnt  = 1'b1;
    end
  end

  always_comb begin
    aux_state_d = aux_state_q;
    aux_addr_d  = aux_addr_q;
    aux_q_d     = aux_q_q;
    starve_d    = starve_q;
    case (aux_state_q)
      AUX_IDLE: if (aux_req) begin
        aux_addr_d  = aux_addr;
        aux_state_d = AUX_WAIT;
      end
      AUX_WAIT: if (!proc_ram) begin
        aux_state_d = AUX_RET;
        starve_d    = '0;
      end else if (starve_q != STARVE_MAX) begin
        starve_d = starve_q + 1'b1;
      end
      AUX_RET: begin
        aux_q_d     = ram_dataOut;
        aux_state_d = AUX_IDLE;
      end
      default: aux_state_d = AUX_IDLE;
    endcase
  end

  always_comb begin
    src_d = SRC_NONE;
    if (proc_ram && !proc_wren)       src_d = SRC_RAM;
    else if (proc_mmio && !proc_wren) src_d = SRC_MMIO;
    mmio_q_d = (proc_mmio && !proc_wren) ? sticky_q : mmio_q_q;
  end

  always_comb begin
    deb_cnt_d   = '0;
    btn_level_d = btn_level_q;
    if (sync2_q != btn_level_q) begin
      if (deb_cnt_q == DEB_MAX) btn_level_d = sync2_q;
      else                      deb_cnt_d   = deb_cnt_q + 1'b1;
    end
    // A press landing on the same edge as a clear must not be lost.
    if (btn_level_d && !btn_level_q) sticky_d = 1'b1;
    else if (proc_mmio)              sticky_d = 1'b0;
    else                             sticky_d = sticky_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      aux_state_q <= AUX_IDLE;
      src_q       <= SRC_NONE;
      aux_addr_q  <= '0;
      aux_q_q     <= '0;
      starve_q    <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      deb_cnt_q   <= '0;
      btn_level_q <= 1'b0;
      sticky_q    <= 1'b0;
      mmio_q_q    <= 1'b0;
    end else begin
      aux_state_q <= aux_state_d;
      src_q       <= src_d;
      aux_addr_q  <= aux_addr_d;
      aux_q_q     <= aux_q_d;
      starve_q    <= starve_d;
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      deb_cnt_q   <= deb_cnt_d;
      btn_level_q <= btn_level_d;
      sticky_q    <= sticky_d;
      mmio_q_q    <= mmio_q_d;
    end
  end

  always_comb begin
    case (src_q)
      SRC_RAM:  proc_q = ram_dataOut;
      SRC_MMIO: proc_q = {31'b0, mmio_q_q};
      default:  proc_q = '0;
    endcase
  end

  assign aux_valid   = (aux_state_q == AUX_RET);
  assign aux_q       = aux_valid ? ram_dataOut : aux_q_q;
  assign aux_starved = (starve_q >= STARVE_MAX);
  assign btn_level   = btn_level_q;

endmodule

// File: doc/dmem_mmio_arbiter.md
Name: dmem_mmio_arbiter

Overview:
- Sits between the processor's dmem port and the single-port RAM (12-bit address, 32-bit data, synchronous read with 1-cycle latency).
- Gives the processor absolute priority for RAM access. A secondary read-only requester (aux, e.g. the game display/scan logic) gets idle RAM cycles through a req/gnt/valid handshake.
- Decodes a memory-mapped button register at BTN_ADDR. The button input is synchronised and debounced, and presses are latched into a sticky flag that the processor polls with lw.

Parameters:
- BTN_ADDR, 24, processor word address of the button MMIO register.
- DEBOUNCE_CYCLES, 16, consecutive stable synced cycles required before btn_level changes (>=1).
- STARVE_LIMIT, 64, wait cycles after which aux_starved asserts.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets the block).
- proc_req  in  1  processor is performing lw/sw this cycle.
- proc_wren  in  1  processor store (valid with proc_req).
- proc_addr  in  32  processor data address.
- proc_data  in  32  processor store data.
- proc_q  out  32  load data, valid the cycle after the request.
- aux_req  in  1  aux read request (level, sampled in IDLE).
- aux_addr  in  12  aux read address (sampled with aux_req).
- aux_gnt  out  1  aux read issued to RAM this cycle.
- aux_valid  out  1  aux_q valid (one cycle pulse).
- aux_q  out  32  aux read data.
- aux_starved  out  1  aux has waited >= STARVE_LIMIT cycles.
- ram_wEn  out  1  RAM write enable.
- ram_addr  out  12  RAM address.
- ram_dataIn  out  32  RAM write data.
- ram_dataOut  in  32  RAM read data (registered in RAM).
- btn_raw  in  1  asynchronous button input.
- btn_level  out  1  debounced button level.

Behaviour:
- Reset (async, reset=0):
  - All outputs 0, aux FSM=IDLE, source tag=NONE.
  - Sync flops, debounce counter, starve counter, sticky flag, btn_level and aux_addr_q all 0.
  - A reset mid-transaction drops the pending aux request; no aux_valid is issued.
- Decode (combinational):
  - proc_ram = proc_req & proc_addr<4096 & proc_addr!=BTN_ADDR.
  - proc_mmio = proc_req & proc_addr==BTN_ADDR.
  - Any other proc_req is out of range: writes ignored, reads return 0.
- RAM mux:
  - If proc_ram: ram_addr=proc_addr[11:0], ram_wEn=proc_wren, ram_dataIn=proc_data.
  - Else if aux FSM=WAIT: ram_addr=aux_addr_q, ram_wEn=0, aux_gnt=1.
  - Else: ram_wEn=0, ram_addr=0, ram_dataIn=0.
- Processor read return:
  - A 2-bit source tag registered on each edge: RAM (proc_ram & !wren), MMIO (proc_mmio & !wren), else NONE.
  - proc_q = ram_dataOut when tag=RAM, {31'b0, mmio_q} when tag=MMIO, 0 when tag=NONE.
  - Latency is exactly 1 cycle in all cases.
- MMIO:
  - A read of BTN_ADDR registers mmio_q=sticky and clears sticky on the same edge.
  - A write to BTN_ADDR clears sticky; data is ignored.
  - A new press edge in the same cycle as a clear wins: sticky stays 1.
  - MMIO accesses never touch RAM, so aux may be granted in that cycle.
- Button path:
  - btn_raw passes through a 2-flop synchroniser to produce btn_s.
  - The counter increments while btn_s!=btn_level and resets to 0 when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and btn_s still differs, btn_level<=btn_s and the counter resets.
  - A btn_level 0->1 transition sets sticky.
- Aux FSM:
  - IDLE: if aux_req, latch aux_addr to aux_addr_q and go to WAIT.
  - WAIT: if !proc_ram, assert aux_gnt and go to RETURN; otherwise stay and increment the saturating starve counter.
  - RETURN: aux_valid=1, aux_q=ram_dataOut, go to IDLE. aux_req is ignored in RETURN; the earliest re-accept is in the next IDLE.
  - aux_q holds its last value outside RETURN.
- Starvation:
  - aux_starved = (starve counter >= STARVE_LIMIT).
  - The counter clears on grant and on reset.
- Processor priority is never violated: aux_gnt=1 implies proc_ram=0 in that cycle.

Test Plan:
1. Processor sw 0xDEADBEEF to address 5, then lw address 5 -> ram_wEn=1 with ram_addr=5 in the store cycle; proc_q=0xDEADBEEF exactly one cycle after the load request.
2. aux_req with aux_addr=5 while the processor is idle -> WAIT for 1 cycle with aux_gnt=1, then aux_valid=1 and aux_q=0xDEADBEEF the next cycle; aux_gnt never asserts in a cycle where proc_ram=1.
3. proc_ram held high for 70 cycles with aux pending -> aux_starved=1 from wait cycle 64; grant occurs the first cycle proc_req=0, and aux_starved then drops to 0.
4. btn_raw glitches high for 5 cycles -> btn_level stays 0 and lw 24 returns 0. Then btn_raw held high for 20 cycles -> btn_level=1 about 18 cycles after the rise (2 sync + 16 debounce). The first lw 24 returns 1, the second returns 0.
5. A press edge in the same cycle as sw to 24 -> sticky remains 1. lw 5000 -> proc_q=0 and ram_wEn stays 0 for sw 5000.
6. reset driven low while the aux FSM is in WAIT and sticky=1 -> all outputs 0 immediately (asynchronous); after release, no aux_valid appears and lw 24 returns 0.
